// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for ram_arbiter.
//   rsp_owner_e - which requester owns the response returning next cycle.
//   WSTRB_READ  - dbus write-strobe value that denotes a read.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } rsp_owner_e;

  localparam logic [3:0] WSTRB_READ = 4'b0000;

endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port-read / single-port-write RAM between
// the instruction-fetch bus (ibus, read-only) and the data bus (dbus).
// One access is granted per cycle; the response returns one cycle later
// on the port that was granted.
//
// Ports:
//   clk, rst                 - clock, async active-high reset
//   i_req/i_addr             - ibus request (byte address)
//   i_gnt/i_rvalid/i_rdata/i_err - ibus grant and response
//   d_req/d_wstrb/d_addr/d_wdata - dbus request (wstrb==0 is a read)
//   d_gnt/d_rvalid/d_rdata/d_err - dbus grant and response
//   ram_*                    - RAM ports; ram_rdata valid cycle after ram_ren
//
// Build option: define RAM_ARB_RR_EN for round-robin arbitration; otherwise
// dbus has fixed priority over ibus.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [AW-1:0]            i_addr,
  output logic                     i_gnt,
  output logic                     i_rvalid,
  output logic [31:0]              i_rdata,
  output logic                     i_err,
  input  logic                     d_req,
  input  logic [3:0]               d_wstrb,
  input  logic [AW-1:0]            d_addr,
  input  logic [31:0]              d_wdata,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [31:0]              d_rdata,
  output logic                     d_err,
  output logic [$clog2(DEPTH)-1:0] ram_waddr,
  output logic [3:0]               ram_wen,
  output logic [31:0]              ram_wdata,
  output logic                     ram_ren,
  output logic [$clog2(DEPTH)-1:0] ram_raddr,
  input  logic [31:0]              ram_rdata
);

  localparam int WW = $clog2(DEPTH);
  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  logic          i_oor, d_oor, d_wr;
  logic [WW-1:0] i_wa, d_wa;

  rsp_owner_e rsp_owner;
  logic       rsp_err, rsp_wr, last_d;

  // Byte offset bits never select anything.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{i_addr[1:0], d_addr[1:0]};

  assign i_wa  = i_addr[WW+1:2];
  assign d_wa  = d_addr[WW+1:2];
  // Compare the full word address so high-order bits beyond the RAM index
  // still flag the access as out of range instead of aliasing.
  assign i_oor = (i_addr >> 2) >= DEPTH_W;
  assign d_oor = (d_addr >> 2) >= DEPTH_W;
  assign d_wr  = d_wstrb != WSTRB_READ;

  // Grants are forced low during reset so every output reads 0 while rst is high.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
`ifdef RAM_ARB_RR_EN
      if (i_req && d_req) begin
        d_gnt = !last_d;
        i_gnt = last_d;
      end else begin
        d_gnt = d_req;
        i_gnt = i_req;
      end
`else
      d_gnt = d_req;
      i_gnt = i_req && !d_req;
`endif
    end
  end

`ifndef RAM_ARB_RR_EN
  // Fixed priority still tracks last_d; nothing consumes it in this build.
  logic unused_last_d;
  assign unused_last_d = last_d;
`endif

  // Out-of-range accesses are granted but never touch the RAM.
  always_comb begin
    ram_wen   = 4'b0000;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_ren   = 1'b0;
    ram_raddr = '0;
    if (d_gnt && !d_oor) begin
      if (d_wr) begin
        ram_wen   = d_wstrb;
        ram_waddr = d_wa;
        ram_wdata = d_wdata;
      end else begin
        ram_ren   = 1'b1;
        ram_raddr = d_wa;
      end
    end else if (i_gnt && !i_oor) begin
      ram_ren   = 1'b1;
      ram_raddr = i_wa;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_owner <= NONE;
      rsp_err   <= 1'b0;
      rsp_wr    <= 1'b0;
      last_d    <= 1'b0;
    end else begin
      if (d_gnt) begin
        rsp_owner <= DBUS;
        rsp_err   <= d_oor;
        rsp_wr    <= d_wr;
      end else if (i_gnt) begin
        rsp_owner <= IBUS;
        rsp_err   <= i_oor;
        rsp_wr    <= 1'b0;
      end else begin
        rsp_owner <= NONE;
        rsp_err   <= 1'b0;
        rsp_wr    <= 1'b0;
      end
      if (d_gnt || i_gnt) last_d <= d_gnt;
    end
  end

  assign i_rvalid = rsp_owner == IBUS;
  assign d_rvalid = rsp_owner == DBUS;
  assign i_err    = i_rvalid && rsp_err;
  assign d_err    = d_rvalid && rsp_err;
  assign i_rdata  = (i_rvalid && !rsp_err) ? ram_rdata : 32'h0;
  assign d_rdata  = (d_rvalid && !rsp_err && !rsp_wr) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural RAM
// (byte-strobed write, one-cycle registered read). Inputs change at the
// falling edge; outputs are sampled 1 time unit later.
module tb_ram_arbiter;

  localparam int DEPTH = 64;
  localparam int AW    = 32;
  localparam int WW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt, i_rvalid, i_err;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic [3:0]    d_wstrb;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt, d_rvalid, d_err;
  logic [31:0]   d_rdata;
  logic [WW-1:0] ram_waddr, ram_raddr;
  logic [3:0]    ram_wen;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          ram_ren;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [DEPTH];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  ram_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_waddr(ram_waddr), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // All DUT outputs must be zero (used during reset).
  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt"},    {30'd0, i_gnt, d_gnt}, 32'd0);
    chk({tag, " rvalid"}, {30'd0, i_rvalid, d_rvalid}, 32'd0);
    chk({tag, " err"},    {30'd0, i_err, d_err}, 32'd0);
    chk({tag, " i_rdata"}, i_rdata, 32'd0);
    chk({tag, " d_rdata"}, d_rdata, 32'd0);
    chk({tag, " ram_en"}, {27'd0, ram_wen, ram_ren}, 32'd0);
  endtask

  logic        exp_d [4];
  logic [31:0] iexp [3];

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wstrb = 4'h0; d_addr = '0; d_wdata = '0;
    ram_rdata = 32'h0;
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'h0;
    mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333;
    mem[4] = 32'hDEADBEEF; mem[8] = 32'hAAAAAAAA;
`ifdef RAM_ARB_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    iexp = '{32'h11111111, 32'h22222222, 32'h33333333};

    // Reset state, with requests pending to show grants are held off.
    cyc(); cyc();
    i_req = 1'b1; d_req = 1'b1; #1;
    chk_all_zero("reset");
    cyc(); i_req = 1'b0; d_req = 1'b0; rst = 1'b0;

    // dbus read of word 4.
    cyc(); d_req = 1'b1; d_addr = 32'h10; d_wstrb = 4'h0; #1;
    chk("rd d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("rd i_gnt", {31'd0, i_gnt}, 32'd0);
    chk("rd ram_ren", {31'd0, ram_ren}, 32'd1);
    chk("rd ram_raddr", 32'(ram_raddr), 32'd4);
    chk("rd ram_wen", {28'd0, ram_wen}, 32'd0);
    cyc(); d_req = 1'b0; #1;
    chk("rd d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("rd d_rdata", d_rdata, 32'hDEADBEEF);
    chk("rd d_err", {31'd0, d_err}, 32'd0);
    chk("rd i_rvalid", {31'd0, i_rvalid}, 32'd0);
    cyc(); #1;
    chk("rd idle rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);

    // Partial write to word 8, then read it back (pipelined).
    cyc(); d_req = 1'b1; d_addr = 32'h20; d_wstrb = 4'b0011; d_wdata = 32'h12345678; #1;
    chk("wr ram_wen", {28'd0, ram_wen}, 32'h3);
    chk("wr ram_ren", {31'd0, ram_ren}, 32'd0);
    chk("wr ram_waddr", 32'(ram_waddr), 32'd8);
    chk("wr ram_wdata", ram_wdata, 32'h12345678);
    cyc(); d_wstrb = 4'h0; #1;
    chk("wr d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("wr d_rdata", d_rdata, 32'd0);
    chk("rb d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("rb ram_ren", {31'd0, ram_ren}, 32'd1);
    cyc(); d_req = 1'b0; #1;
    chk("rb d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("rb d_rdata", d_rdata, 32'hAAAA5678);

    // Fresh reset so last_d starts at 0, then contention for 4 cycles.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    cyc(); i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        cyc();
        #1;
        chk($sformatf("arb%0d d_rvalid", k-1), {31'd0, d_rvalid}, {31'd0, exp_d[k-1]});
        chk($sformatf("arb%0d i_rvalid", k-1), {31'd0, i_rvalid}, {31'd0, !exp_d[k-1]});
      end else #1;
      chk($sformatf("arb%0d d_gnt", k), {31'd0, d_gnt}, {31'd0, exp_d[k]});
      chk($sformatf("arb%0d i_gnt", k), {31'd0, i_gnt}, {31'd0, !exp_d[k]});
      if (exp_d[k] == 1'b0) chk($sformatf("arb%0d i_raddr", k), 32'(ram_raddr), 32'd0);
      else                  chk($sformatf("arb%0d d_raddr", k), 32'(ram_raddr), 32'd4);
    end
    cyc(); i_req = 1'b0; d_req = 1'b0; #1;
    chk("arb3 d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_d[3]});
    chk("arb3 rdata", exp_d[3] ? d_rdata : i_rdata, exp_d[3] ? 32'hDEADBEEF : 32'h11111111);

    // Back-to-back ibus reads at 0x0, 0x4, 0x8.
    for (int k = 0; k < 3; k++) begin
      cyc(); i_req = 1'b1; i_addr = 32'(4*k); #1;
      chk($sformatf("ib%0d i_gnt", k), {31'd0, i_gnt}, 32'd1);
      chk($sformatf("ib%0d raddr", k), 32'(ram_raddr), 32'(k));
      if (k > 0) begin
        chk($sformatf("ib%0d i_rvalid", k-1), {31'd0, i_rvalid}, 32'd1);
        chk($sformatf("ib%0d i_rdata", k-1), i_rdata, iexp[k-1]);
      end
    end
    cyc(); i_req = 1'b0; #1;
    chk("ib2 i_rvalid", {31'd0, i_rvalid}, 32'd1);
    chk("ib2 i_rdata", i_rdata, iexp[2]);
    cyc(); #1;
    chk("ib idle i_rvalid", {31'd0, i_rvalid}, 32'd0);

    // Out of range: dbus at DEPTH*4, ibus with a high address bit set.
    cyc(); d_req = 1'b1; d_addr = 32'(DEPTH*4); d_wstrb = 4'h0; #1;
    chk("oor d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("oor ram_ren", {31'd0, ram_ren}, 32'd0);
    cyc(); d_req = 1'b0; i_req = 1'b1; i_addr = 32'h8000_0010; #1;
    chk("oor d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("oor d_err", {31'd0, d_err}, 32'd1);
    chk("oor d_rdata", d_rdata, 32'd0);
    chk("oori i_gnt", {31'd0, i_gnt}, 32'd1);
    chk("oori ram_ren", {31'd0, ram_ren}, 32'd0);
    cyc(); i_req = 1'b0; #1;
    chk("oori i_rvalid", {31'd0, i_rvalid}, 32'd1);
    chk("oori i_err", {31'd0, i_err}, 32'd1);
    chk("oori i_rdata", i_rdata, 32'd0);

    // Reset in the cycle after a read grant discards the response.
    cyc(); d_req = 1'b1; d_addr = 32'h10; d_wstrb = 4'h0; #1;
    chk("rst d_gnt", {31'd0, d_gnt}, 32'd1);
    cyc(); rst = 1'b1; i_req = 1'b1; #1;
    chk_all_zero("midrst");
    cyc(); rst = 1'b0; i_req = 1'b0; d_req = 1'b0; #1;
    chk("postrst rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    cyc(); #1;
    chk("postrst2 rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
